pid_loop_scheduler: RTL and testbench

PID_LOOP_SCHEDULER -- requirements
Module: pid_loop_scheduler

---
 rtl/pid_sched_pkg.sv | 7 +
 rtl/pid_sample_timer.sv | 15 +
 rtl/pid_loop_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_pid_loop_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared types and defaults for the PID loop scheduler.
package pid_sched_pkg;
    localparam int NUM_CH_DEF = 4;
    localparam int W_DEF      = 16;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
    typedef enum logic [1:0] {SEL_KP = 2'd0, SEL_KI = 2'd1, SEL_KD = 2'd2, SEL_NONE = 2'd3} cfg_sel_e;
endpackage

// File: rtl/pid_sample_timer.sv
// pid_sample_timer: sample tick generator, one tick every sample_period+1 cycles.
module pid_sample_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sample_period,
    output logic        tick
);
    logic [15:0] cnt_q, cnt_d;
    // >= so that shrinking the period below the current count wraps at once
    assign tick = cnt_q >= sample_period;
    always_comb cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/pid_loop_scheduler.sv
// pid_loop_scheduler: time-multiplexes NUM_CH PID loops onto one shared PID datapath,
// sweeping the enabled channels lowest-index first on every sample tick.
module pid_loop_scheduler
    import pid_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int W      = W_DEF,
    parameter int TMO    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         sample_period,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [NUM_CH*W-1:0] setpoint,
    input  logic [NUM_CH*W-1:0] feedback,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic [W-1:0]        cfg_data,
    input  logic                clear_status,
    output logic                pid_req_valid,
    input  logic                pid_req_ready,
    output logic [1:0]          pid_req_ch,
    output logic [W-1:0]        pid_error,
    output logic [W-1:0]        pid_prev_error,
    output logic [W-1:0]        pid_kp,
    output logic [W-1:0]        pid_ki,
    output logic [W-1:0]        pid_kd,
    input  logic                pid_rsp_valid,
    input  logic [W-1:0]        pid_rsp_data,
    output logic [NUM_CH*W-1:0] ctrl_out,
    output logic [NUM_CH-1:0]   ctrl_update,
    output logic                busy,
    output logic                overrun,
    output logic                timeout
);
    localparam int TW = $clog2(TMO + 1);
    typedef logic [W-1:0] word_t;

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d, upd_q, upd_d, nxt_pend;
    logic [1:0]        ch_q, ch_d, nxt;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              valid_q, valid_d, overrun_q, overrun_d, timeout_q, timeout_d;
    logic              tick, load;
    word_t             err_q, err_d, perr_q, perr_d, kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    word_t             gkp_q [NUM_CH], gkp_d [NUM_CH], gki_q [NUM_CH], gki_d [NUM_CH];
    word_t             gkd_q [NUM_CH], gkd_d [NUM_CH], prev_q [NUM_CH], prev_d [NUM_CH];
    word_t             ctrl_q [NUM_CH], ctrl_d [NUM_CH];

    pid_sample_timer u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_period (sample_period),
        .tick          (tick)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        valid_d   = valid_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        perr_d    = perr_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        upd_d     = '0;
        gkp_d     = gkp_q;
        gki_d     = gki_q;
        gkd_d     = gkd_q;
        prev_d    = prev_q;
        ctrl_d    = ctrl_q;
        overrun_d = (overrun_q & ~clear_status) | (tick & (state_q != S_IDLE));
        timeout_d = timeout_q & ~clear_status;
        nxt_pend  = pend_q;
        load      = 1'b0;
        nxt       = '0;
        if (cfg_we && 32'(cfg_ch) < NUM_CH) begin
            gkp_d[cfg_ch] = cfg_sel == SEL_KP ? cfg_data : gkp_q[cfg_ch];
            gki_d[cfg_ch] = cfg_sel == SEL_KI ? cfg_data : gki_q[cfg_ch];
            gkd_d[cfg_ch] = cfg_sel == SEL_KD ? cfg_data : gkd_q[cfg_ch];
        end
        case (state_q)
            S_IDLE: if (tick && |ch_enable) begin
                nxt_pend = ch_enable;
                load     = 1'b1;
            end
            S_ISSUE: if (pid_req_ready) begin
                state_d = S_WAIT;
                valid_d = 1'b0;
                wcnt_d  = '0;
            end
            S_WAIT: if (pid_rsp_valid || wcnt_q == TW'(TMO - 1)) begin
                if (pid_rsp_valid) begin
                    ctrl_d[ch_q] = pid_rsp_data;
                    prev_d[ch_q] = err_q;
                    upd_d[ch_q]  = 1'b1;
                end else begin
                    timeout_d = 1'b1;
                end
                nxt_pend = pend_q & ~(NUM_CH'(1) << ch_q);
                load     = |nxt_pend;
                state_d  = S_IDLE;
            end else begin
                wcnt_d = wcnt_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase
        for (int i = NUM_CH - 1; i >= 0; i--) if (nxt_pend[i]) nxt = 2'(i);
        // payload is captured once on entry to ISSUE and held until accepted
        if (load) begin
            state_d = S_ISSUE;
            valid_d = 1'b1;
            ch_d    = nxt;
            err_d   = setpoint[nxt*W +: W] - feedback[nxt*W +: W];
            perr_d  = prev_q[nxt];
            kp_d    = gkp_q[nxt];
            ki_d    = gki_q[nxt];
            kd_d    = gkd_q[nxt];
        end
        pend_d = nxt_pend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            upd_q     <= '0;
            ch_q      <= '0;
            wcnt_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            perr_q    <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            gkp_q     <= '{default: '0};
            gki_q     <= '{default: '0};
            gkd_q     <= '{default: '0};
            prev_q    <= '{default: '0};
            ctrl_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            upd_q     <= upd_d;
            ch_q      <= ch_d;
            wcnt_q    <= wcnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            perr_q    <= perr_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            gkp_q     <= gkp_d;
            gki_q     <= gki_d;
            gkd_q     <= gkd_d;
            prev_q    <= prev_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign pid_req_valid  = valid_q;
    assign pid_req_ch     = ch_q;
    assign pid_error      = err_q;
    assign pid_prev_error = perr_q;
    assign pid_kp         = kp_q;
    assign pid_ki         = ki_q;
    assign pid_kd         = kd_q;
    assign ctrl_update    = upd_q;
    assign busy           = state_q != S_IDLE;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign ctrl_out[g*W +: W] = ctrl_q[g];
    end
endmodule

// File: tb/tb_pid_loop_scheduler.sv
// tb_pid_loop_scheduler: directed scoreboard bench for pid_loop_scheduler
// with a bench-side model of gains, previous errors and control outputs.
module tb_pid_loop_scheduler;
    typedef struct packed {logic [1:0] ch; logic [15:0] err, perr, kp, ki, kd;} req_t;
    typedef struct packed {logic [1:0] ch; logic [15:0] data;} upd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sample_period;
    logic [3:0]  ch_enable;
    logic [63:0] setpoint, feedback;
    logic        cfg_we;
    logic [1:0]  cfg_ch, cfg_sel;
    logic [15:0] cfg_data;
    logic        clear_status;
    logic        pid_req_valid, pid_req_ready;
    logic [1:0]  pid_req_ch;
    logic [15:0] pid_error, pid_prev_error, pid_kp, pid_ki, pid_kd;
    logic        pid_rsp_valid;
    logic [15:0] pid_rsp_data;
    logic [63:0] ctrl_out;
    logic [3:0]  ctrl_update;
    logic        busy, overrun, timeout;

    logic [15:0] sp [4], fb [4], gkp [4], gki [4], gkd [4], prv [4], ctl [4];
    req_t        exp_req[$];
    upd_t        exp_upd[$];
    req_t        cur;
    int          n_chk = 0, n_fail = 0, cyc_n = 0, t_req = 0, t1 = 0, ones = 0;

    pid_loop_scheduler #(.NUM_CH(4), .W(16), .TMO(255)) dut (
        .clk(clk), .rst_n(rst_n), .sample_period(sample_period), .ch_enable(ch_enable),
        .setpoint(setpoint), .feedback(feedback), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_sel(cfg_sel), .cfg_data(cfg_data), .clear_status(clear_status),
        .pid_req_valid(pid_req_valid), .pid_req_ready(pid_req_ready), .pid_req_ch(pid_req_ch),
        .pid_error(pid_error), .pid_prev_error(pid_prev_error), .pid_kp(pid_kp),
        .pid_ki(pid_ki), .pid_kd(pid_kd), .pid_rsp_valid(pid_rsp_valid),
        .pid_rsp_data(pid_rsp_data), .ctrl_out(ctrl_out), .ctrl_update(ctrl_update),
        .busy(busy), .overrun(overrun), .timeout(timeout)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ctl_model();
        return {ctl[3], ctl[2], ctl[1], ctl[0]};
    endfunction

    task automatic drive_sf();
        for (int i = 0; i < 4; i++) begin
            setpoint[i*16 +: 16] = sp[i];
            feedback[i*16 +: 16] = fb[i];
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            gkp[i] = '0; gki[i] = '0; gkd[i] = '0; prv[i] = '0; ctl[i] = '0;
        end
        exp_req.delete();
        exp_upd.delete();
    endtask

    task automatic cfg(input int c, input int s, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_sel = 2'(s); cfg_data = d;
        cyc(1);
        cfg_we = 1'b0;
        if (s == 0) gkp[c] = d;
        else if (s == 1) gki[c] = d;
        else if (s == 2) gkd[c] = d;
    endtask

    task automatic push_req(input int c);
        req_t r;
        r.ch = 2'(c); r.err = sp[c] - fb[c]; r.perr = prv[c];
        r.kp = gkp[c]; r.ki = gki[c]; r.kd = gkd[c];
        exp_req.push_back(r);
    endtask

    task automatic chk_payload();
        chk("req_ch", 64'(pid_req_ch), 64'(cur.ch));
        chk("req_err", 64'(pid_error), 64'(cur.err));
        chk("req_perr", 64'(pid_prev_error), 64'(cur.perr));
        chk("req_gains", 64'({pid_kp, pid_ki, pid_kd}), 64'({cur.kp, cur.ki, cur.kd}));
    endtask

    task automatic expect_req(input int max);
        int n = 0;
        while (!pid_req_valid && n < max) begin cyc(1); n++; end
        chk("req_valid", 64'(pid_req_valid), 64'd1);
        chk("req_queue_nonempty", 64'(exp_req.size() != 0), 64'd1);
        if (exp_req.size() == 0) return;
        cur = exp_req.pop_front();
        t_req = cyc_n;
        chk_payload();
    endtask

    task automatic accept();
        pid_req_ready = 1'b1;
        cyc(1);
        pid_req_ready = 1'b0;
        chk("valid_drop", 64'(pid_req_valid), 64'd0);
        chk("busy_wait", 64'(busy), 64'd1);
    endtask

    task automatic respond(input logic [15:0] d);
        upd_t u;
        exp_upd.push_back('{ch: cur.ch, data: d});
        prv[cur.ch] = cur.err;
        ctl[cur.ch] = d;
        pid_rsp_valid = 1'b1; pid_rsp_data = d;
        cyc(1);
        pid_rsp_valid = 1'b0;
        u = exp_upd.pop_front();
        chk("upd_pulse", 64'(ctrl_update), 64'(4'b0001 << u.ch));
        chk("ctrl_ch", 64'(ctrl_out[u.ch*16 +: 16]), 64'(u.data));
        chk("ctrl_all", ctrl_out, ctl_model());
        cyc(1);
        chk("upd_clear", 64'(ctrl_update), 64'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, 64'({pid_req_valid, busy, overrun, timeout, ctrl_update, pid_req_ch}), 64'd0);
        chk({tag, "_ctrl"}, ctrl_out, 64'd0);
        chk({tag, "_payload"}, {pid_error, pid_prev_error, pid_kp, pid_ki}, 64'd0);
        chk({tag, "_kd"}, 64'(pid_kd), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; sample_period = '0; ch_enable = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_sel = '0; cfg_data = '0; clear_status = 1'b0; pid_req_ready = 1'b0;
        pid_rsp_valid = 1'b0; pid_rsp_data = '0;
        for (int i = 0; i < 4; i++) begin sp[i] = '0; fb[i] = '0; end
        reset_model();
        drive_sf();
        cyc(3);
        chk_reset("rst_init");
        rst_n = 1'b1;
        cfg(0, 0, 16'd3); cfg(0, 1, 16'd5); cfg(0, 2, 16'd7);
        cfg(1, 0, 16'h11); cfg(1, 1, 16'h12); cfg(1, 2, 16'h13);
        cfg(2, 0, 16'h0202); cfg(2, 1, 16'h21); cfg(2, 2, 16'h22);
        cfg(3, 0, 16'h31); cfg(3, 1, 16'h32); cfg(3, 2, 16'h33);
        cfg(0, 3, 16'hFFFF);

        // single channel, fast datapath, 10-cycle sample period
        sample_period = 16'd9; sp[0] = 16'd100; fb[0] = 16'd40; drive_sf();
        ch_enable = 4'b0001;
        push_req(0);
        expect_req(40); t1 = t_req;
        accept(); respond(16'h0123);
        push_req(0);
        expect_req(40);
        chk("tick_interval", 64'(t_req - t1), 64'd10);
        accept(); respond(16'h0456);
        ch_enable = 4'b0000;
        pid_rsp_valid = 1'b1; pid_rsp_data = 16'hDEAD;
        cyc(1);
        pid_rsp_valid = 1'b0;
        chk("ign_upd", 64'(ctrl_update), 64'd0);
        chk("ign_ctrl", ctrl_out, ctl_model());

        // two channels, stalled datapath, enable change mid-sweep
        sample_period = 16'd49;
        sp[1] = 16'd500; fb[1] = 16'd200; sp[3] = 16'd10; fb[3] = 16'd30; drive_sf();
        ch_enable = 4'b1010;
        push_req(1); push_req(3);
        expect_req(100);
        sp[1] = 16'd250; drive_sf(); ch_enable = 4'b0001;
        for (int i = 0; i < 5; i++) begin cyc(1); chk_payload(); end
        accept(); cyc(1); respond(16'h0AAA);
        expect_req(5); accept(); respond(16'h0BBB);
        chk("ovr_none", 64'(overrun), 64'd0);
        chk("idle_after_sweep", 64'(busy), 64'd0);
        ch_enable = 4'b1010;
        push_req(1); push_req(3);
        expect_req(100); accept(); respond(16'h0CCC);
        expect_req(5); accept(); respond(16'h0DDD);

        // error wrap-around and a gain write while the request is held
        ch_enable = 4'b0100; sp[2] = 16'd0; fb[2] = 16'd1; drive_sf();
        push_req(2);
        expect_req(100);
        cfg(2, 0, 16'h2222);
        chk_payload();
        accept(); respond(16'h0E0E);
        sp[2] = 16'd5; fb[2] = 16'd5; drive_sf();
        push_req(2);
        expect_req(100); accept(); respond(16'h0F0F);
        ch_enable = 4'b0000;

        // overrun with a slow datapath; set beats clear
        sample_period = 16'd2;
        chk("ovr_pre", 64'(overrun), 64'd0);
        ch_enable = 4'b0001;
        push_req(0);
        expect_req(10);
        ch_enable = 4'b0000;
        accept();
        cyc(4);
        chk("ovr_set", 64'(overrun), 64'd1);
        clear_status = 1'b1; ones = 0;
        for (int i = 0; i < 6; i++) begin cyc(1); ones += int'(overrun); end
        clear_status = 1'b0;
        chk("ovr_set_wins", 64'(ones), 64'd2);
        cyc(9); respond(16'h1234);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        clear_status = 1'b1; cyc(1); clear_status = 1'b0;
        chk("ovr_clear", 64'(overrun), 64'd0);

        // response timeout, then reset while waiting
        sample_period = 16'd999; ch_enable = 4'b0011;
        push_req(0); push_req(1);
        expect_req(1100);
        ch_enable = 4'b0000;
        accept();
        cyc(254);
        chk("tmo_pre", 64'({timeout, pid_req_valid}), 64'd0);
        cyc(1);
        chk("tmo_set", 64'(timeout), 64'd1);
        chk("tmo_ctrl", ctrl_out, ctl_model());
        chk("tmo_upd", 64'(ctrl_update), 64'd0);
        expect_req(0);
        accept();
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        reset_model();
        sample_period = 16'd9; ch_enable = 4'b0001;
        cyc(2);
        rst_n = 1'b1;
        push_req(0);
        cyc(9);
        chk("rst_first_tick_early", 64'(pid_req_valid), 64'd0);
        cyc(1);
        expect_req(0); accept(); respond(16'h0777);
        ch_enable = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
